// File: rtl/divisor_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_secuencial (with helper restador)
//  Brief    : Multi-cycle unsigned restoring divider, one quotient bit/clock.
//  Revision : 1.0
// ============================================================================

module restador #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         carry_o
);
    logic [W:0] w_full;

    assign w_full  = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o  = w_full[W-1:0];
    // carry = no borrow, i.e. a_i >= b_i
    assign carry_o = ~w_full[W];
endmodule

module divisor_secuencial #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [N-1:0] dividendo_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] cociente_o,
    output logic [N-1:0] residuo_o,
    output logic         div0_o
);
    localparam int              CW       = $clog2(N);
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [1:0]      S_IDLE   = 2'd0;
    localparam logic [1:0]      S_CALC   = 2'd1;
    localparam logic [1:0]      S_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  coc_q, coc_d;
    logic [N-1:0]  res_q, res_d;
    logic          div0_q, div0_d;

    logic [N:0]    w_r_shift;
    logic [N:0]    w_diff;
    logic          w_carry;
    logic [N:0]    w_r_next;
    logic [N-1:0]  w_q_next;
    logic          w_unused;

    assign w_r_shift = {r_q[N-1:0], q_q[N-1]};

    restador #(.W(N + 1)) u_restador (
        .a_i     (w_r_shift),
        .b_i     ({1'b0, b_q}),
        .diff_o  (w_diff),
        .carry_o (w_carry)
    );

    assign w_r_next = w_carry ? w_diff : w_r_shift;
    assign w_q_next = {q_q[N-2:0], w_carry};
    // Partial remainder stays below the divisor, so its MSB never feeds back
    assign w_unused = r_q[N];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        coc_d   = coc_q;
        res_d   = res_q;
        div0_d  = div0_q;
        case (state_q)
            S_CALC: begin
                r_d   = w_r_next;
                q_d   = w_q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    coc_d   = w_q_next;
                    res_d   = w_r_next[N-1:0];
                end
            end
            default: begin
                if (start_i) begin
                    if (divisor_i != '0) begin
                        state_d = S_CALC;
                        q_d     = dividendo_i;
                        b_d     = divisor_i;
                        r_d     = '0;
                        cnt_d   = '0;
                        div0_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        coc_d   = '1;
                        res_d   = dividendo_i;
                        div0_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            coc_q   <= '0;
            res_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            coc_q   <= coc_d;
            res_q   <= res_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o     = (state_q == S_CALC);
    assign done_o     = (state_q == S_DONE);
    assign cociente_o = coc_q;
    assign residuo_o  = res_q;
    assign div0_o     = div0_q;
endmodule

`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divisor_secuencial
//  Brief    : Scoreboard bench for divisor_secuencial (N=4 directed, N=8 sweep).
//  Revision : 1.0
// ============================================================================
module tb_divisor_secuencial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start4, busy4, done4, div04;
    logic [3:0] dvd4, dvs4, coc4, res4;
    logic       start8, busy8, done8, div08;
    logic [7:0] dvd8, dvs8, coc8, res8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       d0;
        int         acc;
        int         due;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;
    bit   mon_en = 1'b1;
    logic [7:0] a8, b8;

    divisor_secuencial #(.N(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4),
        .dividendo_i(dvd4), .divisor_i(dvs4),
        .busy_o(busy4), .done_o(done4),
        .cociente_o(coc4), .residuo_o(res4), .div0_o(div04)
    );

    divisor_secuencial #(.N(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8),
        .dividendo_i(dvd8), .divisor_i(dvs8),
        .busy_o(busy8), .done_o(done8),
        .cociente_o(coc8), .residuo_o(res8), .div0_o(div08)
    );

    // Monitor: pops the scoreboard on every done pulse, checks busy every cycle
    always @(negedge clk) begin
        exp_t e;
        bit   eb;
        ncyc = ncyc + 1;
        if (done4) begin
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected: done_o=1 at cycle %0d, required 0", ncyc);
            end else begin
                e = sb4.pop_front();
                if ({coc4, res4, div04} !== {e.q[3:0], e.r[3:0], e.d0} || ncyc != e.due) begin
                    errors++;
                    $display("FAIL result4: got q=%0d r=%0d div0=%0b cyc=%0d, required q=%0d r=%0d div0=%0b cyc=%0d",
                             coc4, res4, div04, ncyc, e.q[3:0], e.r[3:0], e.d0, e.due);
                end
            end
        end
        if (mon_en) begin
            eb = (sb4.size() > 0) && !sb4[0].d0 && (ncyc > sb4[0].acc) && (ncyc < sb4[0].due);
            checks++;
            if (busy4 !== eb) begin
                errors++;
                $display("FAIL busy4: got %0b at cycle %0d, required %0b", busy4, ncyc, eb);
            end
        end
        if (done8) begin
            checks++;
            if (sb8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected: done_o=1 at cycle %0d, required 0", ncyc);
            end else begin
                e = sb8.pop_front();
                if ({coc8, res8, div08} !== {e.q, e.r, e.d0} || ncyc != e.due || busy8 !== 1'b0) begin
                    errors++;
                    $display("FAIL result8: got q=%0d r=%0d div0=%0b cyc=%0d, required q=%0d r=%0d div0=%0b cyc=%0d",
                             coc8, res8, div08, ncyc, e.q, e.r, e.d0, e.due);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b);
        start4 = 1'b1;
        dvd4   = a;
        dvs4   = b;
    endtask

    task automatic push4(input logic [3:0] q, input logic [3:0] r, input logic d0);
        exp_t e;
        e.q   = {4'd0, q};
        e.r   = {4'd0, r};
        e.d0  = d0;
        e.acc = ncyc;
        e.due = ncyc + (d0 ? 1 : 5);
        sb4.push_back(e);
    endtask

    task automatic drain4();
        for (int i = 0; i < 40 && sb4.size() != 0; i++) step(1);
        checks++;
        if (sb4.size() != 0) begin
            errors++;
            $display("FAIL timeout4: %0d results pending, required 0", sb4.size());
            sb4.delete();
        end
    endtask

    task automatic div4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] q, input logic [3:0] r, input logic d0);
        go4(a, b);
        push4(q, r, d0);
        step(1);
        start4 = 1'b0;
        drain4();
        step(1);
    endtask

    task automatic div8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.d0  = (b == 8'd0);
        e.q   = e.d0 ? 8'hFF : a / b;
        e.r   = e.d0 ? a : a % b;
        e.acc = ncyc;
        e.due = ncyc + (e.d0 ? 1 : 9);
        start8 = 1'b1;
        dvd8   = a;
        dvs8   = b;
        sb8.push_back(e);
        step(1);
        start8 = 1'b0;
        for (int i = 0; i < 40 && sb8.size() != 0; i++) step(1);
        checks++;
        if (sb8.size() != 0) begin
            errors++;
            $display("FAIL timeout8: a=%0d b=%0d pending, required done", a, b);
            sb8.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        step(2);
        checks++;
        if ({busy4, done4, div04, coc4, res4} !== 11'd0 || {busy8, done8, div08, coc8, res8} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got n4=%h n8=%h, required 0",
                     {busy4, done4, div04, coc4, res4}, {busy8, done8, div08, coc8, res8});
        end
        rst_n = 1'b1;
        step(1);

        div4(4'd13, 4'd3,  4'd4,  4'd1, 1'b0);
        div4(4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
        div4(4'd5,  4'd7,  4'd0,  4'd5, 1'b0);
        div4(4'd15, 4'd15, 4'd1,  4'd0, 1'b0);
        div4(4'd0,  4'd9,  4'd0,  4'd0, 1'b0);
        div4(4'd9,  4'd0,  4'd15, 4'd9, 1'b1);

        // Start during CALC is ignored; start in the DONE cycle is accepted
        go4(4'd14, 4'd4); push4(4'd3, 4'd2, 1'b0);
        step(1); start4 = 1'b0;
        step(1); go4(4'd7, 4'd2);
        step(1); start4 = 1'b0;
        step(2); go4(4'd7, 4'd2); push4(4'd3, 4'd1, 1'b0);
        step(1); start4 = 1'b0;
        drain4();
        step(1);

        // Asynchronous reset in the middle of an iteration
        mon_en = 1'b0;
        go4(4'd11, 4'd2);
        step(1); start4 = 1'b0;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, div04, coc4, res4} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, required 0", {busy4, done4, div04, coc4, res4});
        end
        step(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(8);
        div4(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);

        div8(8'd200, 8'd0);
        div8(8'd200, 8'd1);
        div8(8'd255, 8'd255);
        div8(8'd254, 8'd255);
        div8(8'd0,   8'd7);
        for (int i = 0; i < 200; i++) begin
            a8 = 8'($urandom_range(0, 255));
            case (i % 8)
                0:       b8 = 8'd0;
                1:       b8 = 8'd1;
                2:       b8 = 8'd255;
                default: b8 = 8'($urandom_range(1, 255));
            endcase
            div8(a8, b8);
        end

        step(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
